// File: rtl/dmi_arb_pkg.sv
// Shared types and constants for the two-requester DMI strobe arbiter.
package dmi_arb_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  // Owner encoding, also used as the round-robin "last granted" value.
  localparam logic OWNER_JTAG = 1'b0;
  localparam logic OWNER_SYS  = 1'b1;

  // Arbiter FSM state encoding.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t S_IDLE  = 2'd0;
  localparam arb_state_t S_ISSUE = 2'd1;
  localparam arb_state_t S_WAIT  = 2'd2;
  localparam arb_state_t S_RESP  = 2'd3;

  // One captured request: what gets replayed onto the DMI strobe bus.
  typedef struct packed {
    logic                  wr;
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] wdata;
  } dmi_req_t;

endpackage

// File: rtl/dmi_req_arbiter_if.sv
// Bundles both requester handshakes and the shared DMI strobe bus.
// slave = arbiter side, master = requesters plus DMI target side.
interface dmi_req_arbiter_if;
  import dmi_arb_pkg::*;

  logic                  jtag_req_valid;
  logic                  jtag_req_ready;
  logic                  jtag_req_wr;
  logic [DMI_ADDR_W-1:0] jtag_req_addr;
  logic [DMI_DATA_W-1:0] jtag_req_wdata;
  logic                  jtag_rsp_valid;
  logic [DMI_DATA_W-1:0] jtag_rsp_rdata;

  logic                  sys_req_valid;
  logic                  sys_req_ready;
  logic                  sys_req_wr;
  logic [DMI_ADDR_W-1:0] sys_req_addr;
  logic [DMI_DATA_W-1:0] sys_req_wdata;
  logic                  sys_rsp_valid;
  logic [DMI_DATA_W-1:0] sys_rsp_rdata;

  logic                  dmi_en;
  logic                  dmi_wr_en;
  logic [DMI_ADDR_W-1:0] dmi_addr;
  logic [DMI_DATA_W-1:0] dmi_wdata;
  logic [DMI_DATA_W-1:0] dmi_rdata;

  modport slave (
    input  jtag_req_valid, jtag_req_wr, jtag_req_addr, jtag_req_wdata,
    output jtag_req_ready, jtag_rsp_valid, jtag_rsp_rdata,
    input  sys_req_valid, sys_req_wr, sys_req_addr, sys_req_wdata,
    output sys_req_ready, sys_rsp_valid, sys_rsp_rdata,
    output dmi_en, dmi_wr_en, dmi_addr, dmi_wdata,
    input  dmi_rdata
  );

  modport master (
    output jtag_req_valid, jtag_req_wr, jtag_req_addr, jtag_req_wdata,
    input  jtag_req_ready, jtag_rsp_valid, jtag_rsp_rdata,
    output sys_req_valid, sys_req_wr, sys_req_addr, sys_req_wdata,
    input  sys_req_ready, sys_rsp_valid, sys_rsp_rdata,
    input  dmi_en, dmi_wr_en, dmi_addr, dmi_wdata,
    output dmi_rdata
  );

endinterface

// File: rtl/dmi_rr_arb2.sv
// Two-way round-robin selector. A lone requester always wins; on a tie the
// requester that was not granted last wins. rr_last only moves on a grant.
module dmi_rr_arb2
  import dmi_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_jtag_i,
  input  logic req_sys_i,
  input  logic grant_en_i,
  output logic gnt_jtag_o,
  output logic gnt_sys_o,
  output logic gnt_owner_o
);

  logic rr_last_q, rr_last_d;
  logic winner;
  logic gnt_any;

  // Pick the winner and compute the next rr_last value.
  always_comb begin
    if (req_jtag_i && req_sys_i) begin
      winner = ~rr_last_q;
    end else begin
      winner = req_sys_i ? OWNER_SYS : OWNER_JTAG;
    end
    gnt_any   = grant_en_i & (req_jtag_i | req_sys_i);
    rr_last_d = gnt_any ? winner : rr_last_q;
  end

  assign gnt_jtag_o  = gnt_any & (winner == OWNER_JTAG);
  assign gnt_sys_o   = gnt_any & (winner == OWNER_SYS);
  assign gnt_owner_o = winner;

  // rr_last resets to SYS so JTAG wins the very first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_last_q <= OWNER_SYS;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/dmi_req_arbiter.sv
// Shares one DMI strobe interface between the JTAG DMI master and a
// system-side debug agent. One transaction in flight: accept in IDLE, one
// ISSUE strobe cycle, optional WAIT for read latency, one RESP pulse back
// to the owner. RD_LATENCY must be in 1..4 (counter is 2 bits).
module dmi_req_arbiter
  import dmi_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic               core_clk,
  input  logic               core_rst_n,
  dmi_req_arbiter_if.slave   bus,
  output logic               busy,
  output logic               owner
);

  arb_state_t            state_q, state_d;
  dmi_req_t              cap_q;
  dmi_req_t              sel_req;
  logic                  owner_q;
  logic [1:0]            cnt_q;
  logic [DMI_DATA_W-1:0] rsp_data_q;

  logic idle;
  logic gnt_jtag, gnt_sys, gnt_any, gnt_owner;
  logic in_issue, in_wait, in_resp;

  assign idle     = (state_q == S_IDLE);
  assign in_issue = (state_q == S_ISSUE);
  assign in_wait  = (state_q == S_WAIT);
  assign in_resp  = (state_q == S_RESP);

  dmi_rr_arb2 u_rr_arb (
    .clk_i       (core_clk),
    .rst_ni      (core_rst_n),
    .req_jtag_i  (bus.jtag_req_valid),
    .req_sys_i   (bus.sys_req_valid),
    .grant_en_i  (idle),
    .gnt_jtag_o  (gnt_jtag),
    .gnt_sys_o   (gnt_sys),
    .gnt_owner_o (gnt_owner)
  );

  assign gnt_any = gnt_jtag | gnt_sys;

  // Ready is only ever given in IDLE, and only to the winner.
  assign bus.jtag_req_ready = gnt_jtag;
  assign bus.sys_req_ready  = gnt_sys;

  // Mux the winning requester's fields toward the capture register.
  always_comb begin
    sel_req = '{wr: bus.jtag_req_wr, addr: bus.jtag_req_addr, wdata: bus.jtag_req_wdata};
    if (gnt_sys) begin
      sel_req = '{wr: bus.sys_req_wr, addr: bus.sys_req_addr, wdata: bus.sys_req_wdata};
    end
  end

  // Next-state logic for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_any) state_d = S_ISSUE;
      S_ISSUE: state_d = cap_q.wr ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt_q == 2'd0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, capture, latency counter and response data registers.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q    <= S_IDLE;
      cap_q      <= '0;
      owner_q    <= OWNER_JTAG;
      cnt_q      <= 2'd0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (idle && gnt_any) begin
        cap_q   <= sel_req;
        owner_q <= gnt_owner;
      end
      if (in_issue) begin
        if (cap_q.wr) begin
          rsp_data_q <= '0;
        end else begin
          cnt_q <= 2'(RD_LATENCY - 1);
        end
      end
      if (in_wait) begin
        if (cnt_q == 2'd0) begin
          rsp_data_q <= bus.dmi_rdata;
        end else begin
          cnt_q <= cnt_q - 2'd1;
        end
      end
    end
  end

  // DMI strobes come straight from registered state so they never glitch;
  // address and write data simply hold the last captured request.
  assign bus.dmi_en    = in_issue;
  assign bus.dmi_wr_en = in_issue & cap_q.wr;
  assign bus.dmi_addr  = cap_q.addr;
  assign bus.dmi_wdata = cap_q.wdata;

  // Response pulse goes only to the owner; the other side sees zeros.
  assign bus.jtag_rsp_valid = in_resp & (owner_q == OWNER_JTAG);
  assign bus.sys_rsp_valid  = in_resp & (owner_q == OWNER_SYS);
  assign bus.jtag_rsp_rdata = bus.jtag_rsp_valid ? rsp_data_q : '0;
  assign bus.sys_rsp_rdata  = bus.sys_rsp_valid ? rsp_data_q : '0;

  assign busy  = ~idle;
  assign owner = owner_q;

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Directed bench for dmi_req_arbiter with a response scoreboard.
module tb_dmi_req_arbiter;
  import dmi_arb_pkg::*;

  localparam int RD1 = 1;
  localparam int RD3 = 3;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst3_n = 1'b0;
  logic busy, owner, busy3, owner3;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmi_req_arbiter_if bus ();
  dmi_req_arbiter_if bus3 ();

  dmi_req_arbiter #(.RD_LATENCY(RD1)) dut (
    .core_clk (clk), .core_rst_n (rst_n), .bus (bus.slave), .busy (busy), .owner (owner)
  );
  dmi_req_arbiter #(.RD_LATENCY(RD3)) dut3 (
    .core_clk (clk), .core_rst_n (rst3_n), .bus (bus3.slave), .busy (busy3), .owner (owner3)
  );

  typedef struct {
    logic        who;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] exp_mem  [128];
  logic [31:0] tgt_mem  [128];
  logic [31:0] tgt3_mem [128];
  int          due1 = -1;
  int          due3 = -1;
  logic [6:0]  ta1, ta3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_jtag(input logic v, input logic wr, input logic [6:0] a, input logic [31:0] d);
    bus.jtag_req_valid = v; bus.jtag_req_wr = wr; bus.jtag_req_addr = a; bus.jtag_req_wdata = d;
  endtask

  task automatic set_sys(input logic v, input logic wr, input logic [6:0] a, input logic [31:0] d);
    bus.sys_req_valid = v; bus.sys_req_wr = wr; bus.sys_req_addr = a; bus.sys_req_wdata = d;
  endtask

  task automatic wait_ready(output logic who, output int at);
    at  = -1;
    who = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.jtag_req_ready || bus.sys_req_ready) begin
        who = bus.sys_req_ready;
        at  = cyc;
        break;
      end
    end
    chk("ready_timeout", 32'(at >= 0), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 32'({busy, owner, bus.dmi_en, bus.dmi_wr_en, bus.dmi_addr,
                            bus.jtag_req_ready, bus.sys_req_ready,
                            bus.jtag_rsp_valid, bus.sys_rsp_valid}), 0);
    chk({tag, "_wdata"}, bus.dmi_wdata, 0);
    chk({tag, "_rdata"}, bus.jtag_rsp_rdata | bus.sys_rsp_rdata, 0);
  endtask

  // DMI target for the RD_LATENCY=1 instance: data valid only in T+1.
  initial begin
    forever begin
      @(posedge clk); #2;
      bus.dmi_rdata = (cyc == due1) ? tgt_mem[ta1] : 32'hBAD0_0000 + cyc;
      @(negedge clk);
      if (bus.dmi_en) begin
        if (bus.dmi_wr_en) tgt_mem[bus.dmi_addr] = bus.dmi_wdata;
        else begin ta1 = bus.dmi_addr; due1 = cyc + RD1; end
      end
    end
  end

  // DMI target for the RD_LATENCY=3 instance.
  initial begin
    forever begin
      @(posedge clk); #2;
      bus3.dmi_rdata = (cyc == due3) ? tgt3_mem[ta3] : 32'hBAD3_0000 + cyc;
      @(negedge clk);
      if (bus3.dmi_en) begin
        if (bus3.dmi_wr_en) tgt3_mem[bus3.dmi_addr] = bus3.dmi_wdata;
        else begin ta3 = bus3.dmi_addr; due3 = cyc + RD3; end
      end
    end
  end

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.jtag_req_ready || bus.sys_req_ready)
        chk("ready_excl", 32'(bus.jtag_req_ready & bus.sys_req_ready), 0);
      if (bus.jtag_rsp_valid || bus.sys_rsp_valid) begin
        chk("rsp_excl", 32'(bus.jtag_rsp_valid & bus.sys_rsp_valid), 0);
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 32'({bus.jtag_rsp_valid, bus.sys_rsp_valid}), 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_who", 32'(bus.sys_rsp_valid), 32'(mon_e.who));
          chk("rsp_data", mon_e.who ? bus.sys_rsp_rdata : bus.jtag_rsp_rdata, mon_e.data);
          chk("rsp_other_rdata", mon_e.who ? bus.jtag_rsp_rdata : bus.sys_rsp_rdata, 0);
          chk("rsp_cycle", cyc, mon_e.at);
        end
      end
    end
  end

  initial begin
    logic who, exp_who;
    int   a, prev, gap, en_cnt, rsp_at, j_i, s_i;

    for (int i = 0; i < 128; i++) begin
      exp_mem[i] = 32'hC0DE_0000 | i; tgt_mem[i] = 32'hC0DE_0000 | i; tgt3_mem[i] = 32'hC0DE_0000 | i;
    end
    exp_mem[7'h11] = 32'h1234_5678; tgt_mem[7'h11] = 32'h1234_5678; tgt3_mem[7'h11] = 32'h1234_5678;
    set_jtag(0, 0, 0, 0);
    set_sys(0, 0, 0, 0);
    bus3.jtag_req_valid = 0; bus3.jtag_req_wr = 0; bus3.jtag_req_addr = 0; bus3.jtag_req_wdata = 0;
    bus3.sys_req_valid = 0; bus3.sys_req_wr = 0; bus3.sys_req_addr = 0; bus3.sys_req_wdata = 0;

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check_zero("reset");
    tick();
    rst_n = 1'b1; rst3_n = 1'b1;
    tick();

    // Both valid from reset: JTAG writes 0x20+i, sys reads them back; J,S,J,S...
    j_i = 0; s_i = 0; prev = 0; gap = 0; exp_who = OWNER_JTAG;
    set_jtag(1, 1, 7'h20, 32'hA000_0000);
    set_sys(1, 0, 7'h20, 0);
    for (int k = 0; k < 8; k++) begin
      wait_ready(who, a);
      if (a < 0) break;
      chk("alt_who", 32'(who), 32'(exp_who));
      if (k > 0) chk("alt_spacing", a - prev, gap);
      if (exp_who == OWNER_JTAG) begin
        exp_mem[32 + j_i] = 32'hA000_0000 + j_i;
        sbq.push_back('{who: OWNER_JTAG, data: 32'h0, at: a + 2});
        gap = 3; j_i++;
      end else begin
        sbq.push_back('{who: OWNER_SYS, data: exp_mem[32 + s_i], at: a + 2 + RD1});
        gap = 3 + RD1; s_i++;
      end
      prev = a; exp_who = ~exp_who;
      tick();
      set_jtag(k < 7, 1, 7'(32 + j_i), 32'hA000_0000 + j_i);
      set_sys(k < 7, 0, 7'(32 + s_i), 0);
    end
    repeat (6) tick();
    chk("alt_drain", sbq.size(), 0);

    // Single JTAG write; rr_last becomes JTAG.
    set_jtag(1, 1, 7'h10, 32'hDEAD_BEEF);
    wait_ready(who, a);
    chk("wr_who", 32'(who), 32'(OWNER_JTAG));
    exp_mem[16] = 32'hDEAD_BEEF;
    sbq.push_back('{who: OWNER_JTAG, data: 32'h0, at: a + 2});
    tick();
    set_jtag(0, 0, 0, 0);
    @(negedge clk);
    chk("wr_strobe", 32'({bus.dmi_en, bus.dmi_wr_en}), 32'b11);
    chk("wr_addr", 32'(bus.dmi_addr), 32'h10);
    chk("wr_wdata", bus.dmi_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_strobe_end", 32'({bus.dmi_en, bus.dmi_wr_en}), 0);
    chk("wr_addr_hold", 32'(bus.dmi_addr), 32'h10);
    tick();

    // Tie with rr_last=JTAG: sys read wins, JTAG read waits for next IDLE.
    set_sys(1, 0, 7'h11, 0);
    set_jtag(1, 0, 7'h10, 0);
    wait_ready(who, a);
    chk("tie_sys_wins", 32'(who), 32'(OWNER_SYS));
    chk("tie_owner_reg", 32'(owner), 32'(OWNER_JTAG));
    sbq.push_back('{who: OWNER_SYS, data: exp_mem[17], at: a + 2 + RD1});
    prev = a;
    tick();
    set_sys(0, 0, 0, 0);
    @(negedge clk);
    chk("rd_strobe", 32'({bus.dmi_en, bus.dmi_wr_en}), 32'b10);
    chk("rd_addr", 32'(bus.dmi_addr), 32'h11);
    chk("rd_owner", 32'(owner), 32'(OWNER_SYS));
    wait_ready(who, a);
    chk("tie_jtag_next", 32'(who), 32'(OWNER_JTAG));
    chk("tie_jtag_wait", a - prev, 3 + RD1);
    sbq.push_back('{who: OWNER_JTAG, data: exp_mem[16], at: a + 2 + RD1});
    tick();
    set_jtag(0, 0, 0, 0);
    repeat (5) tick();
    chk("tie_drain", sbq.size(), 0);

    // Sys valid pulses for one cycle while the FSM is in ISSUE.
    set_jtag(1, 1, 7'h40, 32'h5555_AAAA);
    wait_ready(who, a);
    exp_mem[64] = 32'h5555_AAAA;
    sbq.push_back('{who: OWNER_JTAG, data: 32'h0, at: a + 2});
    tick();
    set_jtag(0, 0, 0, 0);
    set_sys(1, 0, 7'h40, 0);
    @(negedge clk);
    chk("wd_in_issue", 32'(bus.dmi_en), 1);
    chk("wd_no_ready_issue", 32'(bus.sys_req_ready), 0);
    tick();
    set_sys(0, 0, 0, 0);
    en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("wd_no_ready", 32'(bus.jtag_req_ready | bus.sys_req_ready), 0);
      en_cnt += int'(bus.dmi_en);
    end
    chk("wd_no_issue", en_cnt, 0);
    chk("wd_idle", 32'(busy), 0);
    chk("wd_drain", sbq.size(), 0);

    // Reset asserted in WAIT during a JTAG read: dropped, no response.
    tick();
    set_jtag(1, 0, 7'h40, 0);
    wait_ready(who, a);
    tick();
    set_jtag(0, 0, 0, 0);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("rst_wait");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_idle", 32'(busy), 0);
    set_jtag(1, 0, 7'h40, 0);
    wait_ready(who, a);
    chk("rst_reissue_who", 32'(who), 32'(OWNER_JTAG));
    sbq.push_back('{who: OWNER_JTAG, data: exp_mem[64], at: a + 2 + RD1});
    tick();
    set_jtag(0, 0, 0, 0);
    repeat (5) tick();
    chk("rst_drain", sbq.size(), 0);

    // RD_LATENCY=3 instance: sys read of 0x11, response expected in A+5.
    bus3.sys_req_valid = 1; bus3.sys_req_wr = 0; bus3.sys_req_addr = 7'h11;
    a = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus3.sys_req_ready) begin a = cyc; break; end
    end
    chk("rd3_accept", 32'(a >= 0), 1);
    tick();
    bus3.sys_req_valid = 0;
    @(negedge clk);
    chk("rd3_strobe", 32'({bus3.dmi_en, bus3.dmi_wr_en}), 32'b10);
    rsp_at = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus3.sys_rsp_valid) begin
        rsp_at = cyc;
        chk("rd3_data", bus3.sys_rsp_rdata, 32'h1234_5678);
        chk("rd3_jtag_quiet", 32'(bus3.jtag_rsp_valid), 0);
        break;
      end
    end
    chk("rd3_latency", rsp_at, a + 2 + RD3);

    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
